// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//   Sequential signed radix-2 Booth multiplier. One Booth step is performed
//   per clock through a single Adder_subtractor instance that is WIDTH+1 bits
//   wide. The extra bit keeps M = -2^(WIDTH-1) exact when it is negated.
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous, active-high reset
//     in_valid      operand pair valid (upstream handshake)
//     in_ready      block can accept an operand pair (high only in IDLE)
//     multiplicand  signed operand M, WIDTH bits
//     multiplier    signed operand Q, WIDTH bits
//     out_valid     product valid (high only in DONE)
//     out_ready     consumer accepts the product
//     product       signed product M*Q, 2*WIDTH bits, held while out_valid
//     busy          high while the Booth iterations run (CALC)
//
//   Timing: accepting edge -> WIDTH CALC edges -> DONE until out_ready.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Adder_subtractor
//   out = x + y       when carryin = 0
//   out = x - y       when carryin = 1  (x + ~y + 1)
//   carryout is the carry out of the MSB.
//
//   Ports
//     x, y      width-bit operands
//     carryin   0 = add, 1 = subtract
//     out       width-bit result
//     carryout  carry out of the top bit
// ---------------------------------------------------------------------------
module Adder_subtractor #(
    parameter int width = 4
) (
    input  logic [width-1:0] x,
    input  logic [width-1:0] y,
    input  logic             carryin,
    output logic [width-1:0] out,
    output logic             carryout
);

    logic [width:0] sum;

    // Subtraction reuses the adder: invert y and inject the +1 through the carry.
    always_comb begin
        sum = {1'b0, x} + {1'b0, (y ^ {width{carryin}})} + {{width{1'b0}}, carryin};
    end

    assign out      = sum[width-1:0];
    assign carryout = sum[width];

endmodule

module booth_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Booth working registers: accumulator A, multiplier shift register Q,
    // the appended bit q_m1 and the sign-extended multiplicand.
    logic signed [WIDTH:0] acc;
    logic signed [WIDTH:0] m_ext;
    logic [WIDTH-1:0]      q_reg;
    logic                  q_m1;
    logic [CNT_W-1:0]      count;

    // Adder/subtractor connection.
    logic                  do_sub;
    logic                  do_op;
    logic [WIDTH:0]        adder_out;
    logic                  carry_unused;

    // Result of one Booth step, before it is registered.
    logic signed [WIDTH:0] acc_sel;
    logic signed [WIDTH:0] acc_next;
    logic [WIDTH-1:0]      q_next;
    logic                  q_m1_next;
    logic [2*WIDTH-1:0]    product_next;

    assign do_sub = q_reg[0] & ~q_m1;     // pair 10: A - M
    assign do_op  = q_reg[0] ^ q_m1;      // pairs 01/10 touch the accumulator

    Adder_subtractor #(
        .width (WIDTH + 1)
    ) u_addsub (
        .x        (acc),
        .y        (m_ext),
        .carryin  (do_sub),
        .out      (adder_out),
        .carryout (carry_unused)
    );

    // One Booth step: optional add/sub, then arithmetic shift right of
    // {A, Q, q_m1}. The no-op pairs bypass the adder entirely.
    always_comb begin
        acc_sel      = do_op ? $signed(adder_out) : acc;
        acc_next     = acc_sel >>> 1;
        q_next       = {acc_sel[0], q_reg[WIDTH-1:1]};
        q_m1_next    = q_reg[0];
        product_next = {acc_next[WIDTH-1:0], q_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            acc       <= '0;
            m_ext     <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                // ---- IDLE: capture operands on the accepting edge ----
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_ext     <= $signed({multiplicand[WIDTH-1], multiplicand});
                        q_reg     <= multiplier;
                        acc       <= '0;
                        q_m1      <= 1'b0;
                        count     <= '0;
                        state     <= CALC;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                // ---- CALC: one Booth step per edge, WIDTH steps in total ----
                CALC: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        product   <= product_next;
                    end
                end

                // ---- DONE: hold the product until the consumer takes it ----
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        product   <= '0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    product   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    // Reference: plain signed integer multiply, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        int ms;
        int qs;
        logic signed [31:0] p;
        ms = int'($signed(m));
        qs = int'($signed(q));
        p  = ms * qs;
        return p[2*W-1:0];
    endfunction

    // Advance one edge and land 1 time unit after it (sampling/driving point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and return once it has been accepted.
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, output bit ok);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        ok           = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Wait for out_valid. edges counts the accepting edge as 1.
    task automatic wait_valid(output int edges, output int busy_cnt, output int ready_hi, output bit ok);
        edges    = 1;
        busy_cnt = 0;
        ready_hi = 0;
        ok       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_hi++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        multiplicand = '0;
        multiplier = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h want=00", product); end
    endtask

    task automatic test_basic();
        bit ok;
        int edges, bcnt, rhi;
        start_op(4'd3, 4'd5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_accept got=timeout want=accepted"); end
        wait_valid(edges, bcnt, rhi, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_valid got=timeout want=out_valid"); end
        total++;
        if (edges != W + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", edges, W + 1); end
        total++;
        if (bcnt != W) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bcnt, W); end
        total++;
        if (rhi != 0) begin bad++; $display("FAIL basic_in_ready_low got=%0d high samples want=0", rhi); end
        total++;
        if (product !== 8'h0F) begin bad++; $display("FAIL basic_product got=%h want=0f", product); end
        tick();
    endtask

    task automatic test_corners();
        logic [W-1:0]   cm  [4];
        logic [W-1:0]   cq  [4];
        logic [2*W-1:0] cex [4];
        bit ok;
        int edges, bcnt, rhi;
        cm  = '{4'h8, 4'h8, 4'h7, 4'h0};
        cq  = '{4'h8, 4'h7, 4'hF, 4'h8};
        cex = '{8'h40, 8'hC8, 8'hF9, 8'h00};
        for (int i = 0; i < 4; i++) begin
            start_op(cm[i], cq[i], ok);
            wait_valid(edges, bcnt, rhi, ok);
            total++;
            if (!ok || product !== cex[i]) begin
                bad++;
                $display("FAIL corner_%0d got=%h valid=%b want=%h", i, product, ok, cex[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_q[$];
        logic [7:0] pv;
        logic [2*W-1:0] e;
        int idx, cyc, last;
        bit acc;
        idx = 0;
        cyc = 0;
        last = -1;
        pv = idx[7:0];
        multiplicand = pv[7:4];
        multiplier   = pv[3:0];
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        while ((idx < 256 || exp_q.size() > 0) && cyc < 2000) begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sweep_extra got=%h want=no_result", product);
                end else begin
                    e = exp_q.pop_front();
                    if (product !== e) begin
                        bad++;
                        $display("FAIL sweep_product got=%h want=%h", product, e);
                    end
                end
            end
            acc = 1'b0;
            if (in_ready && in_valid) begin
                exp_q.push_back(ref_mul(multiplicand, multiplier));
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 6) begin
                        bad++;
                        $display("FAIL sweep_spacing got=%0d want=6", cyc - last);
                    end
                end
                last = cyc;
                acc = 1'b1;
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 256) begin
                    pv = idx[7:0];
                    multiplicand = pv[7:4];
                    multiplier   = pv[3:0];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (idx < 256 || exp_q.size() > 0) begin
            bad++;
            $display("FAIL sweep_timeout got=%0d accepted want=256", idx);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int edges, bcnt, rhi;
        out_ready = 1'b0;
        start_op(4'd6, 4'hD, ok);
        wait_valid(edges, bcnt, rhi, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_valid got=timeout want=out_valid"); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || product !== 8'hEE || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got valid=%b product=%h in_ready=%b want 1/ee/0",
                         i, out_valid, product, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        multiplicand = 4'd2;
        multiplier = 4'hE;
        in_valid = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'h00) begin
            bad++;
            $display("FAIL bp_release got in_ready=%b valid=%b product=%h want 1/0/00", in_ready, out_valid, product);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_accept got busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        wait_valid(edges, bcnt, rhi, ok);
        total++;
        if (!ok || product !== 8'hFC) begin bad++; $display("FAIL bp_next_product got=%h want=fc", product); end
        tick();
    endtask

    task automatic test_reset_midop();
        bit ok;
        int edges, bcnt, rhi;
        start_op(4'd5, 4'd5, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_calc got in_ready=%b valid=%b product=%h busy=%b want 1/0/00/0",
                     in_ready, out_valid, product, busy);
        end
        start_op(4'd2, 4'd3, ok);
        wait_valid(edges, bcnt, rhi, ok);
        total++;
        if (!ok || product !== 8'h06) begin bad++; $display("FAIL rst_after_product got=%h want=06", product); end
        tick();
        // Reset while a finished product is waiting.
        out_ready = 1'b0;
        start_op(4'd3, 4'd3, ok);
        wait_valid(edges, bcnt, rhi, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'h00) begin
            bad++;
            $display("FAIL rst_done got in_ready=%b valid=%b product=%h want 1/0/00", in_ready, out_valid, product);
        end
    endtask

    task automatic test_operand_hold();
        bit ok;
        bit seen;
        start_op(4'd4, 4'hE, ok);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            tick();
        end
        total++;
        if (!seen || product !== 8'hF8) begin bad++; $display("FAIL hold_product got=%h want=f8", product); end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        bit done;
        logic [W-1:0] m, q;
        logic [2*W-1:0] e;
        for (int n = 0; n < 40; n++) begin
            m = W'($urandom);
            q = W'($urandom);
            e = ref_mul(m, q);
            start_op(m, q, ok);
            done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    total++;
                    if (product !== e) begin
                        bad++;
                        $display("FAIL random_product m=%h q=%h got=%h want=%h", m, q, product, e);
                    end
                    if (out_ready) done = 1'b1;
                end
                tick();
            end
            total++;
            if (!done) begin bad++; $display("FAIL random_timeout m=%h q=%h got=no_handshake want=handshake", m, q); end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_operand_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Sequential signed (two's-complement) radix-2 Booth multiplier, built directly around the team's Adder_subtractor module.
- Feeds that module's x/y/carryin inputs one Booth step per clock and consumes its out.
- Upstream valid/ready handshake accepts an operand pair; downstream valid/ready handshake returns a 2*WIDTH-bit product.
- Sits in the datapath as the multiply stage beside the add/sub unit.

Parameters:
WIDTH, 4, operand width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
multiplicand  input  WIDTH  signed operand M.
multiplier  input  WIDTH  signed operand Q.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts the product.
product  output  2*WIDTH  signed product M*Q.
busy  output  1  high while in CALC.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. Internal A, Q, q_m1 and counter are all cleared.
- Reset is checked ahead of every other event. Asserting rst mid-CALC or in DONE abandons the operation with no output, and the block is in IDLE on the next cycle.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==CALC).
- IDLE, when in_valid && in_ready at an edge:
  - latch M (sign-extended to WIDTH+1), Q=multiplier, A=0 (WIDTH+1 bits), q_m1=0, count=0;
  - go to CALC.
- CALC, each edge performs one Booth step:
  - {Q[0],q_m1}=01: A_new = A + M.
  - {Q[0],q_m1}=10: A_new = A - M.
  - 00 or 11: A_new = A.
  - Then arithmetic shift right of {A_new,Q,q_m1} by 1, with the MSB of A_new replicated.
  - count increments.
  - When count==WIDTH-1 at the edge, the last step is taken and the state goes to DONE.
- Arithmetic unit: one Adder_subtractor instance with width=WIDTH+1.
  - x=A, y=M_ext.
  - carryin=1 for subtract, 0 for add; its carryout is ignored.
  - The no-op case uses A directly, not the adder output.
  - The WIDTH+1 accumulator guarantees a correct result for M = -2^(WIDTH-1).
- DONE: product = {A[WIDTH-1:0], Q}. It is registered and held stable while out_valid=1.
  - out_valid && out_ready at an edge: go to IDLE and clear product to 0.
  - Without out_ready, hold DONE indefinitely (backpressure).
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge.
- Throughput: the accepting edge, WIDTH CALC edges, and at least one DONE edge.
  - With out_ready tied high, at most one result per WIDTH+2 cycles.
- No new operand is accepted in CALC or DONE, because in_ready is low in those states.
  - in_valid during CALC/DONE is ignored; the upstream holds the pair until in_ready.
- Operand inputs are sampled only on the accepting edge. Changes afterwards do not affect the result in flight.
- Full range: every WIDTH-bit signed pair yields the exact 2*WIDTH-bit result. (-2^(W-1))*(-2^(W-1)) = +2^(2W-2) fits.

Test Plan:
All scenarios use WIDTH=4 with out_ready=1 unless stated.
1. Accept M=3, Q=5 -> product=8'h0F, with out_valid exactly 5 edges after acceptance; busy is high for 4 cycles; in_ready=0 throughout.
2. Corner values:
   - M=-8, Q=-8 -> product=8'h40.
   - M=-8, Q=7 -> 8'hC8.
   - M=7, Q=-1 -> 8'hF9.
   - M=0, Q=-8 -> 8'h00.
3. Exhaustive sweep of all 256 (M,Q) pairs, back-to-back with in_valid held high -> every product matches the signed reference model, and the accept-to-accept spacing is 6 edges.
4. Backpressure: out_ready=0 for 10 cycles after 6*(-3) completes -> out_valid stays 1, product holds 8'hEE, and in_ready stays 0. Raising out_ready -> IDLE on the next edge and a new operand is accepted the edge after.
5. Reset mid-op: assert rst during the 2nd CALC cycle of 5*5 -> next cycle state is IDLE with in_ready=1, out_valid=0, product=0; a following 2*3 returns 8'h06.
6. Operand hold: change multiplicand/multiplier every cycle during CALC of 4*(-2) -> product is 8'hF8.
